mux_n_pipe: RTL
===============

Name: mux_n_pipe

Overview:
- Parametrised successor to the 2:1 register-destination and datapath selectors.
- N-way, WIDTH-bit selector with a registered output stage and valid/ready handshake.
- A 2-entry skid buffer gives full throughput without a combinational ready path.
- Sits between the decode/select control and any registered consumer: write-back select, ALU operand select, PC-source select.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_INPUTS, 4, number of selectable inputs; legal range 2..16.
- SEL_W, $clog2(NUM_INPUTS), select width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- data_in  input  NUM_INPUTS*WIDTH  flattened inputs; input k = data_in[k*WIDTH +: WIDTH]
- sel  input  SEL_W  input index, sampled with in_valid
- in_valid  input  1  upstream presents data_in/sel
- in_ready  output  1  block can accept this cycle
- out_data  output  WIDTH  selected word
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts out_data
- sel_err  output  1  sticky illegal-select flag (optional feature)
- err_clr  input  1  clears sel_err (optional feature)

Behaviour:
- Clocking and reset: single clock. reset is asynchronous, active-high.
- Values while reset is asserted and at its release:
  - out_valid=0, out_data=0, sel_err=0.
  - Skid entry empty, so in_ready=1.
- Storage: main register (drives out_data/out_valid) plus one skid register.
  - in_ready = NOT skid_valid, taken from flops with no combinational path from out_ready.
- Accept: in_valid && in_ready at a rising edge captures data_in[sel] (not the sel index).
  - Nothing is captured when in_valid=0.
- Latency: accepted word appears on out_data one cycle after acceptance when main is empty or draining.
- Transfer out: out_valid && out_ready at an edge retires the main entry.
- States by {skid_valid, main_valid}:
  - EMPTY (0,0):
    - accept → ONE.
  - ONE (0,1):
    - accept without out_ready → FULL; the word goes to skid.
    - accept with out_ready → ONE; main is replaced by the new word.
    - out_ready without accept → EMPTY.
    - neither → hold.
  - FULL (1,1): in_ready=0.
    - out_ready → skid moves to main → ONE.
    - Otherwise hold.
- Order is strictly FIFO; no word is dropped or duplicated.
- Back-to-back with out_ready held high: one word per cycle, in_ready stays 1.
- out_data and out_valid hold stable while out_valid=1 and out_ready=0.
- Select range:
  - sel >= NUM_INPUTS selects all-zero data and is still accepted as a normal transfer.
  - This happens only when NUM_INPUTS is not a power of two.
- Reset mid-operation: both entries are discarded immediately and in-flight data is lost. No output glitch is required beyond the reset values.

Optional Feature:
- Macro: MUX_N_PIPE_SEL_CHECK_EN.
- Defined:
  - An accepted transfer with sel >= NUM_INPUTS, or with sel containing X/Z in simulation, sets sel_err on the next edge.
  - The word is stored as zero.
  - sel_err stays 1 until err_clr is sampled high. If err_clr and a new error occur in the same cycle, set wins.
  - Simulation additionally emits $display with the offending sel.
- Undefined: sel_err is tied 0, err_clr is ignored, no $display; out-of-range data is still zero.

Test Plan:
- Reset then idle:
  - assert reset asynchronously mid-cycle → out_valid=0, out_data=0, in_ready=1 immediately.
  - Release reset → values hold.
- Single transfer, WIDTH=32, NUM_INPUTS=4:
  - inputs 0x11111111/0x22222222/0x33333333/0x44444444, sel=2, in_valid one cycle, out_ready=1 → out_data=0x33333333 with out_valid=1 exactly one cycle later, then out_valid=0.
- Backpressure:
  - out_ready=0, send sel=0 then sel=1 → second accepted, in_ready=0 after it, third held.
  - Raise out_ready → 0x11111111 then 0x22222222 then the third word, in order, no loss.
- Streaming:
  - out_ready=1, in_valid=1 for 8 cycles with sel cycling 0..3 → 8 outputs on consecutive cycles matching the sel sequence, in_ready never drops.
- Illegal select, NUM_INPUTS=3, macro defined:
  - sel=3 accepted → out_data=0, sel_err=1 next cycle and sticky.
  - Pulse err_clr → sel_err=0.
  - err_clr in the same cycle as another sel=3 → sel_err stays 1.
- Reset while FULL:
  - fill both entries with out_ready=0, then pulse reset → out_valid=0 and in_ready=1.
  - Next accepted word is the first output.

Source files
------------

// File: rtl/mux_n_pipe.sv
// rtl/mux_n_pipe.sv - N-way registered selector with valid/ready and 2-entry skid buffer
// Optional sticky illegal-select flag enabled by `define MUX_N_PIPE_SEL_CHECK_EN.
module mux_n_pipe #(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 4,
    parameter int SEL_W      = $clog2(NUM_INPUTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_INPUTS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]            sel,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        sel_err,
    input  logic                        err_clr
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic [WIDTH-1:0] sel_word;
    logic             sel_bad;
    logic             accept;
    logic             pop;

    // An index with no matching input leaves the word at zero.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_word = data_in[k*WIDTH +: WIDTH];
            end
        end
        if (sel_bad) begin
            sel_word = '0;
        end
    end

    // Ready comes straight from the state flops so out_ready never reaches in_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = ONE;
            ONE: begin
                if (accept && !pop) begin
                    state_next = FULL;
                end else if (!accept && pop) begin
                    state_next = EMPTY;
                end
            end
            FULL:    if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_data <= '0;
            skid_data <= '0;
        end else begin
            case (state)
                EMPTY: if (accept) main_data <= sel_word;
                ONE: begin
                    if (accept && pop) begin
                        main_data <= sel_word;
                    end else if (accept) begin
                        skid_data <= sel_word;
                    end
                end
                FULL:    if (pop) main_data <= skid_data;
                default: ;
            endcase
        end
    end

`ifdef MUX_N_PIPE_SEL_CHECK_EN
    logic sel_err_q;

    assign sel_bad = ({1'b0, sel} >= (SEL_W+1)'(NUM_INPUTS)) || $isunknown(sel);
    assign sel_err = sel_err_q;

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else if (accept && sel_bad) begin
            sel_err_q <= 1'b1;
            $display("mux_n_pipe: illegal sel=%b accepted", sel);
        end else if (err_clr) begin
            sel_err_q <= 1'b0;
        end
    end
`else
    logic unused_err_clr;

    assign sel_bad        = 1'b0;
    assign sel_err        = 1'b0;
    assign unused_err_clr = err_clr;
`endif

endmodule
